// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver with a first-word-fall-through receive FIFO.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset
//   rx         - serial input, idle high, asynchronous to clk
//   data_out   - FIFO head byte, meaningful while rx_valid is high
//   rx_valid   - FIFO non-empty
//   rx_ready   - consumer takes the head byte this cycle
//   fifo_count - number of buffered bytes
//   rx_busy    - receiver is inside a frame or waiting for the line to go high
//   frame_err  - one-cycle pulse: stop bit sampled low
//   overrun    - one-cycle pulse: good byte dropped because the FIFO was full
module uart_rx_buffered #(
    parameter int unsigned CLK_PER_BIT = 10,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    output logic [7:0]                    data_out,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rx_busy,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int unsigned HALF = CLK_PER_BIT / 2;
    localparam int unsigned CW   = $clog2(CLK_PER_BIT);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned PW   = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     sync_q;
    logic           rx_s;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           good_c;
    logic           ferr_d;

    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic           full_c, pop_c, push_c, ovr_d, valid_d;
    logic [7:0]     data_d;
    logic [PW-1:0]  count_d;

    // Two-flop synchroniser; flops reset to the idle (high) line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];

    // Receive FSM next-state: start validation, mid-bit data sampling, stop check.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        good_c  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == CW'(CLK_PER_BIT - 1)) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rx_s;
                    bit_d          = bit_q + 3'(1);
                    if (bit_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == CW'(CLK_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        good_c  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // Hold off until the line returns high so a break cannot retrigger.
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO control; a same-cycle pop frees the slot so a push into a full FIFO is accepted.
    always_comb begin
        full_c  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop_c   = rx_valid && rx_ready;
        push_c  = good_c && (!full_c || pop_c);
        ovr_d   = good_c && full_c && !pop_c;
        wr_d    = wr_q + PW'(push_c);
        rd_d    = rd_q + PW'(pop_c);
        valid_d = (wr_d != rd_d);
        count_d = wr_d - rd_d;
        // Next head byte: bypass the write when it lands in the slot being exposed.
        if (push_c && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
            data_d = shift_q;
        end else begin
            data_d = mem_q[rd_d[AW-1:0]];
        end
    end

    // FSM, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            data_out   <= '0;
            rx_valid   <= 1'b0;
            fifo_count <= '0;
            rx_busy    <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            data_out   <= data_d;
            rx_valid   <= valid_d;
            fifo_count <= count_d;
            rx_busy    <= (state_d != S_IDLE);
            frame_err  <= ferr_d;
            overrun    <= ovr_d;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_q[AW-1:0]] <= shift_q;
    end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: directed self-checking bench for uart_rx_buffered.
module tb_uart_rx_buffered;

    localparam int unsigned CPB   = 10;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_ready;
    logic [7:0] data_out;
    logic       rx_valid;
    logic [2:0] fifo_count;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    uart_rx_buffered #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data_out   (data_out),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_count (fifo_count),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_checks = 0;

    logic [7:0] rxq [$];
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int busy_cnt = 0;

    // Observe outputs mid-cycle: log handshakes, error pulses and busy cycles.
    always @(negedge clk) begin
        if (reset) begin
            if (frame_err)            ferr_cnt++;
            if (overrun)              ovr_cnt++;
            if (rx_busy)              busy_cnt++;
            if (rx_valid && rx_ready) rxq.push_back(data_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_rx(input string tag, input int base, input logic [7:0] exp [$]);
        logic [31:0] got;
        check({tag, "_len"}, 32'(rxq.size() - base), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            got = (base + i < rxq.size()) ? 32'(rxq[base + i]) : 32'hDEAD;
            check($sformatf("%s_byte%0d", tag, i), got, 32'(exp[i]));
        end
    endtask

    // Every drive step starts and ends 1 time unit after a rising edge.
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Locate cycle T0+1 (first cycle with rx_busy high), bounded.
    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rx_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         base, f0, o0, b0;
        bit         ok;
        logic [7:0] exp [$];
        logic [7:0] partial;

        reset    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_out",   32'(data_out),   32'h0);
        check("rst_rx_valid",   32'(rx_valid),   32'h0);
        check("rst_fifo_count", 32'(fifo_count), 32'h0);
        check("rst_rx_busy",    32'(rx_busy),    32'h0);
        check("rst_frame_err",  32'(frame_err),  32'h0);
        check("rst_overrun",    32'(overrun),    32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(5);

        // Back-to-back loopback frames with the consumer always ready.
        base = rxq.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        rx_ready = 1'b1;
        send_frame(8'hB9, 1'b1);
        send_frame(8'hC9, 1'b1);
        send_frame(8'h1D, 1'b1);
        send_frame(8'h1C, 1'b1);
        idle(20);
        exp = '{8'hB9, 8'hC9, 8'h1D, 8'h1C};
        check_rx("loop", base, exp);
        check("loop_ferr",  32'(ferr_cnt - f0), 32'd0);
        check("loop_ovr",   32'(ovr_cnt - o0),  32'd0);
        check("loop_count", 32'(fifo_count),    32'd0);

        // Start-bit glitch: 3 low clocks, busy for exactly HALF cycles.
        base = rxq.size(); f0 = ferr_cnt; o0 = ovr_cnt; b0 = busy_cnt;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(30);
        check("glitch_busy_cycles", 32'(busy_cnt - b0),     32'd5);
        check("glitch_busy_now",    32'(rx_busy),           32'd0);
        check("glitch_no_push",     32'(rxq.size() - base), 32'd0);
        check("glitch_valid",       32'(rx_valid),          32'd0);
        check("glitch_ferr",        32'(ferr_cnt - f0),     32'd0);
        check("glitch_ovr",         32'(ovr_cnt - o0),      32'd0);

        // Framing error followed by a held-low line, then a good frame.
        base = rxq.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("ferr_wait_high_busy", 32'(rx_busy), 32'd1);
        repeat (15) @(posedge clk);
        #1;
        idle(10);
        send_frame(8'hA3, 1'b1);
        idle(20);
        check("ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
        check("ferr_ovr",    32'(ovr_cnt - o0),  32'd0);
        exp = '{8'hA3};
        check_rx("ferr", base, exp);

        // Overrun: exact stop-sample latency on the first byte, then fill past depth.
        rx_ready = 1'b0;
        base = rxq.size(); o0 = ovr_cnt;
        fork
            send_frame(8'h01, 1'b1);
            begin
                wait_busy(ok);
                check("lat_t0_found", 32'(ok), 32'd1);
                repeat (94) @(negedge clk);
                check("lat_count_at_S", 32'(fifo_count), 32'd0);
                check("lat_busy_at_S",  32'(rx_busy),    32'd1);
                @(negedge clk);
                check("lat_count_at_S1", 32'(fifo_count), 32'd1);
                check("lat_valid_at_S1", 32'(rx_valid),   32'd1);
                check("lat_data_at_S1",  32'(data_out),   32'h01);
                check("lat_busy_at_S1",  32'(rx_busy),    32'd0);
            end
        join
        send_frame(8'h02, 1'b1);
        send_frame(8'h03, 1'b1);
        send_frame(8'h04, 1'b1);
        idle(5);
        check("ovr_none_at_full", 32'(ovr_cnt - o0), 32'd0);
        send_frame(8'h05, 1'b1);
        idle(10);
        check("ovr_pulses",  32'(ovr_cnt - o0), 32'd1);
        check("ovr_count",   32'(fifo_count),   32'd4);
        check("ovr_head",    32'(data_out),     32'h01);
        rx_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rx_ready = 1'b0;
        exp = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_rx("ovr_drain", base, exp);
        check("ovr_drained_count", 32'(fifo_count), 32'd0);
        check("ovr_drained_valid", 32'(rx_valid),   32'd0);

        // Full FIFO with a pop in exactly the stop-sample cycle of a new frame.
        base = rxq.size();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        idle(5);
        check("simpop_full", 32'(fifo_count), 32'd4);
        o0 = ovr_cnt;
        fork
            send_frame(8'h66, 1'b1);
            begin
                wait_busy(ok);
                check("simpop_t0_found", 32'(ok), 32'd1);
                repeat (94) @(posedge clk);
                #1;
                rx_ready = 1'b1;
                @(posedge clk);
                #1;
                rx_ready = 1'b0;
                @(negedge clk);
                check("simpop_ovr_pulse", 32'(overrun),    32'd0);
                check("simpop_count",     32'(fifo_count), 32'd4);
                check("simpop_head",      32'(data_out),   32'h22);
            end
        join
        idle(5);
        check("simpop_ovr_total", 32'(ovr_cnt - o0), 32'd0);
        rx_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rx_ready = 1'b0;
        exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
        check_rx("simpop", base, exp);

        // Reset during data bit 4 with one byte already buffered.
        send_frame(8'h77, 1'b1);
        idle(5);
        check("mrst_pre_count", 32'(fifo_count), 32'd1);
        partial = 8'hA5;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(partial[i]);
        rx = partial[4];
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mrst_data_out",   32'(data_out),   32'h0);
        check("mrst_rx_valid",   32'(rx_valid),   32'h0);
        check("mrst_fifo_count", 32'(fifo_count), 32'h0);
        check("mrst_rx_busy",    32'(rx_busy),    32'h0);
        check("mrst_frame_err",  32'(frame_err),  32'h0);
        check("mrst_overrun",    32'(overrun),    32'h0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(20);
        check("mrst_post_busy",  32'(rx_busy),  32'd0);
        check("mrst_post_valid", 32'(rx_valid), 32'd0);
        base = rxq.size();
        rx_ready = 1'b1;
        send_frame(8'h3C, 1'b1);
        idle(20);
        exp = '{8'h3C};
        check_rx("mrst", base, exp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
